// File: rtl/slave2wb_pkg.sv
// slave2wb shared types and helpers.
// Bridges Wishbone B4 pipelined masters onto req/gnt/rvalid slaves.
package slave2wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int unsigned AW_DEF      = 32;
  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned MAX_OUT_DEF = 4;
  localparam int unsigned TIMEOUT_DEF = 255;

  function automatic int unsigned cnt_width(
    input int unsigned max_out
  );
    int unsigned w;
    w = $clog2(max_out + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/slave2wb_timeout.sv
// Hung-slave watchdog: counts enabled cycles, pulses expire_o
// on the cycle the count reaches TIMEOUT-1.
module slave2wb_timeout
  import slave2wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned TW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
  localparam logic ENABLED = (TIMEOUT != 0);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr_i)     timer_d = '0;
    else if (en_i) timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  assign expire_o = ENABLED & en_i & ~clr_i
                  & (timer_q == LAST);

endmodule

// File: rtl/slave2wb_pipe.sv
// Wishbone B4 pipelined slave to req/gnt/rvalid bridge with
// in-order responses, orphan draining and a hung-slave timeout.
module slave2wb_pipe
  import slave2wb_pkg::*;
#(
  parameter int unsigned AW              = AW_DEF,
  parameter int unsigned DW              = DW_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUT_DEF,
  parameter int unsigned TIMEOUT         = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_cyc,
  input  logic            wb_stb,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_adr,
  input  logic [DW/8-1:0] wb_sel,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack,
  output logic            wb_err,
  output logic            wb_stall,
  output logic            slv_req,
  output logic            slv_we,
  output logic [AW-1:0]   slv_addr,
  output logic [DW/8-1:0] slv_be,
  output logic [DW-1:0]   slv_wdata,
  input  logic            slv_gnt,
  input  logic            slv_rvalid,
  input  logic [DW-1:0]   slv_rdata,
  input  logic            slv_err
);

  localparam int unsigned CW = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   dat_q, dat_d;

  logic accept, rsp, take;
  logic tmr_en, tmr_clr, expire;

  assign slv_req   = wb_cyc & wb_stb
                   & (state_q != DRAIN)
                   & (count_q < CMAX);
  assign slv_we    = wb_we;
  assign slv_addr  = wb_adr;
  assign slv_be    = wb_sel;
  assign slv_wdata = wb_dat_i;

  assign accept   = slv_req & slv_gnt;
  assign wb_stall = ~accept;

  // A response with nothing outstanding is stale and dropped.
  assign rsp  = slv_rvalid & (count_q != '0);
  assign take = rsp & (state_q != DRAIN);

  always_comb begin
    count_d = count_q;
    if (accept & ~rsp)      count_d = count_q + CW'(1);
    else if (~accept & rsp) count_d = count_q - CW'(1);
  end

  assign tmr_en  = (state_q == ACTIVE) & (count_q != '0)
                 & ~slv_rvalid;
  assign tmr_clr = slv_rvalid | (state_q != ACTIVE);

  slave2wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (expire)                state_d = DRAIN;
        else if (count_d == '0)    state_d = IDLE;
        else if (!wb_cyc)          state_d = DRAIN;
      end
      DRAIN: begin
        if (count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d = take & ~slv_err;
    err_d = (take & slv_err) | expire;
    dat_d = take ? slv_rdata : dat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_err   = err_q;
  assign wb_dat_o = dat_q;

endmodule
